// File: rtl/z_mc_controller.sv
// -----------------------------------------------------------------------------
// z_mc_controller
//   Multi-cycle MIPS-subset controller. One instruction is fetched, decoded and
//   executed over several cycles through a single shared memory port that may
//   stall via mem_ready. Register file reads are combinational (rd1/rd2) and
//   writes are a one-cycle strobe (reg_write/reg_waddr/reg_wdata).
//
// Parameters
//   XLEN      datapath / PC width (32 or 64); instructions are always 32 bits
//   RESET_PC  PC loaded on reset
//   CNT_W     width of the retired-instruction counter (wraps)
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   mem_rdata, mem_ready            memory read data / request completed
//   mem_addr, mem_wdata             memory address / store data
//   mem_read, mem_write             memory requests (never both high)
//   rd1, rd2                        register file read data for rs/rt
//   rs_addr, rt_addr                register file read addresses (IR fields)
//   reg_write, reg_waddr, reg_wdata register file write strobe/address/data
//   pc, state                       current PC and FSM state code
//   illegal, halted, retired        bad-opcode pulse, halt flag, retire count
// -----------------------------------------------------------------------------
module z_mc_controller #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  mem_rdata,
  input  logic             mem_ready,
  input  logic [XLEN-1:0]  rd1,
  input  logic [XLEN-1:0]  rd2,
  output logic [XLEN-1:0]  mem_addr,
  output logic [XLEN-1:0]  mem_wdata,
  output logic             mem_read,
  output logic             mem_write,
  output logic [4:0]       rs_addr,
  output logic [4:0]       rt_addr,
  output logic             reg_write,
  output logic [4:0]       reg_waddr,
  output logic [XLEN-1:0]  reg_wdata,
  output logic [XLEN-1:0]  pc,
  output logic [2:0]       state,
  output logic             illegal,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_BEQ  = 6'h04,
                         OP_BNE   = 6'h05, OP_ADDI = 6'h08, OP_ANDI = 6'h0C,
                         OP_ORI   = 6'h0D, OP_LW   = 6'h23, OP_SW   = 6'h2B,
                         OP_HALT  = 6'h3F;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_ADD = 6'h20,
                         FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR  = 6'h25,
                         FN_SLT = 6'h2A;

  state_t           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d, a_q, b_q, alu_q, mdr_q;
  logic [31:0]      ir_q;
  logic [CNT_W-1:0] retired_q;

  logic [5:0]       opcode, funct;
  logic [4:0]       shamt;
  logic [XLEN-1:0]  imm_sext, imm_zext, jump_target, alu_res;
  logic             bad_op, retire, load_ir, load_ab, load_alu, load_mdr;
  logic             rd_req, wr_req;

  assign opcode      = ir_q[31:26];
  assign funct       = ir_q[5:0];
  assign shamt       = ir_q[10:6];
  assign imm_sext    = {{(XLEN-16){ir_q[15]}}, ir_q[15:0]};
  assign imm_zext    = {{(XLEN-16){1'b0}}, ir_q[15:0]};
  assign jump_target = {pc_q[XLEN-1:28], ir_q[25:0], 2'b00};

  // ALU and opcode/funct legality, evaluated from the latched IR/A/B.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    alu_res = '0;
    bad_op  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  alu_res = a_q + b_q;
          FN_SUB:  alu_res = a_q - b_q;
          FN_AND:  alu_res = a_q & b_q;
          FN_OR:   alu_res = a_q | b_q;
          FN_SLT:  alu_res[0] = $signed(a_q) < $signed(b_q);
          FN_SLL:  alu_res = b_q << shamt;
          FN_SRL:  alu_res = b_q >> shamt;
          default: bad_op = 1'b1;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW:          alu_res = a_q + imm_sext;
      OP_ANDI:                        alu_res = a_q & imm_zext;
      OP_ORI:                         alu_res = a_q | imm_zext;
      OP_BEQ, OP_BNE, OP_J, OP_HALT:  alu_res = '0;
      default:                        bad_op = 1'b1;
    endcase
  end

  // Next-state, PC update and control strobes.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retire    = 1'b0;
    load_ir   = 1'b0;
    load_ab   = 1'b0;
    load_alu  = 1'b0;
    load_mdr  = 1'b0;
    rd_req    = 1'b0;
    wr_req    = 1'b0;
    reg_write = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      S_FETCH: begin
        rd_req = 1'b1;
        if (mem_ready) begin
          load_ir = 1'b1;
          pc_d    = pc_q + XLEN'(4);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        load_ab = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (bad_op) begin
          illegal = 1'b1;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          case (opcode)
            OP_LW, OP_SW: begin
              load_alu = 1'b1;
              state_d  = S_MEM;
            end
            OP_BEQ, OP_BNE: begin
              // pc_q already points at the next sequential instruction.
              if ((a_q == b_q) == (opcode == OP_BEQ)) pc_d = pc_q + (imm_sext << 2);
              retire  = 1'b1;
              state_d = S_FETCH;
            end
            OP_J: begin
              pc_d    = jump_target;
              retire  = 1'b1;
              state_d = S_FETCH;
            end
            OP_HALT: state_d = S_HALT;
            default: begin
              load_alu = 1'b1;
              state_d  = S_WB;
            end
          endcase
        end
      end
      S_MEM: begin
        if (opcode == OP_LW) rd_req = 1'b1;
        else                 wr_req = 1'b1;
        if (mem_ready) begin
          if (opcode == OP_LW) begin
            load_mdr = 1'b1;
            state_d  = S_WB;
          end else begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_WB: begin
        // Writes to $0 are suppressed but the instruction still retires.
        reg_write = (reg_waddr != 5'd0);
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // NOTE: every register here is architectural state with a defined reset value; there is no array storage to leave unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_q     <= '0;
      mdr_q     <= '0;
      retired_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      pc_q    <= pc_d;
      if (load_ir)  ir_q <= mem_rdata[31:0];
      if (load_ab) begin
        a_q <= rd1;
        b_q <= rd2;
      end
      if (load_alu) alu_q <= alu_res;
      if (load_mdr) mdr_q <= mem_rdata;
      if (retire)   retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Requests are pure decodes of registered state, so they hold through a
  // stall; gating with rst_n drops an in-flight request the moment reset hits.
  assign mem_read  = rd_req & rst_n;
  assign mem_write = wr_req & rst_n;
  assign mem_addr  = (state_q == S_MEM) ? alu_q : pc_q;
  assign mem_wdata = b_q;
  assign rs_addr   = ir_q[25:21];
  assign rt_addr   = ir_q[20:16];
  assign reg_waddr = (opcode == OP_RTYPE) ? ir_q[15:11] : ir_q[20:16];
  assign reg_wdata = (opcode == OP_LW) ? mdr_q : alu_q;
  assign pc        = pc_q;
  assign state     = state_q;
  assign halted    = (state_q == S_HALT);
  assign retired   = retired_q;

endmodule

// File: doc/z_mc_controller.md
Name: z_mc_controller

Overview:
- Multi-cycle successor to the single-cycle controller.
- Fetches, decodes and executes one MIPS-subset instruction over several clock cycles through a single shared memory port with a ready handshake.
- Parametrised datapath width, reset vector and retired-instruction counter width.
- Sits between the register file (combinational read, clocked write) and a unified instruction/data memory that may stall.

Parameters:
XLEN, 32, datapath/PC width; legal values 32 or 64; instructions are always 32 bits.
RESET_PC, 0, PC value loaded on reset.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  asynchronous active-low reset.
mem_rdata  in  XLEN  memory read data; instruction in low 32 bits during fetch.
mem_ready  in  1  memory accepted/completed current request this cycle.
rd1  in  XLEN  register file read data for rs_addr.
rd2  in  XLEN  register file read data for rt_addr.
mem_addr  out  XLEN  memory address.
mem_wdata  out  XLEN  store data.
mem_read  out  1  read request.
mem_write  out  1  write request.
rs_addr  out  5  IR[25:21].
rt_addr  out  5  IR[20:16].
reg_write  out  1  one-cycle register write strobe.
reg_waddr  out  5  write register: rd (R-type) or rt (I-type).
reg_wdata  out  XLEN  write data.
pc  out  XLEN  current PC.
state  out  3  FSM state code.
illegal  out  1  one-cycle pulse on unknown opcode/funct.
halted  out  1  high in HALT.
retired  out  CNT_W  retired-instruction count; wraps to 0.

Behaviour:
- Reset, asynchronous: pc=RESET_PC, IR=0, A=B=ALUOut=MDR=0, retired=0, state=FETCH. All strobes (mem_read, mem_write, reg_write, illegal, halted) are 0. Reset mid-request abandons the request immediately.
- State codes: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- FETCH:
  - mem_read=1, mem_addr=pc.
  - Hold both until mem_ready=1 at a rising edge.
  - On that edge: IR<=mem_rdata[31:0], pc<=pc+4, go to DECODE.
- DECODE: A<=rd1, B<=rd2, go to EXEC.
- EXEC, by opcode IR[31:26]:
  - 0x00 R-type, by funct: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed, result 0/1), sll 0x00 and srl 0x02 (B shifted by shamt IR[10:6]). ALUOut<=result, go to WB.
  - addi 0x08: A+sext(imm16). andi 0x0C and ori 0x0D: zero-extended imm16. ALUOut<=result, go to WB.
  - lw 0x23, sw 0x2B: ALUOut<=A+sext(imm16), go to MEM.
  - beq 0x04, bne 0x05: if taken, pc<=pc+(sext(imm16)<<2), where pc already holds PC+4. Retire, go to FETCH.
  - j 0x02: pc<={pc[XLEN-1:28],IR[25:0],2'b00}. Retire, go to FETCH.
  - 0x3F: go to HALT. The halt instruction is not counted.
  - Any other opcode or funct: illegal pulse for one cycle, no state change except pc advance. Counted as retired. Go to FETCH.
- Arithmetic wraps modulo 2^XLEN; no overflow trap. sext extends to XLEN.
- MEM:
  - lw: mem_read=1, mem_addr=ALUOut; hold until mem_ready, then MDR<=mem_rdata, go to WB.
  - sw: mem_write=1, mem_addr=ALUOut, mem_wdata=B; hold until mem_ready, then retire, go to FETCH.
- WB:
  - reg_write=1 for exactly one cycle; reg_wdata = MDR (lw) or ALUOut (others).
  - Retire, go to FETCH.
  - reg_waddr=0: reg_write forced 0, instruction still retires.
- Retire means retired<=retired+1 on the transition edge.
- Latency with mem_ready tied high: R-type/I-ALU 4 cycles, lw 5, sw 4, branch/j 3. Each stall cycle adds one.
- HALT: halted=1, no memory requests, pc and retired frozen until reset.
- mem_read and mem_write are never both high. Request outputs are registered-state decodes, stable throughout a stall.

Test Plan:
- Reset with RESET_PC=0x100, mem_ready=1, fetch "addi $1,$0,-5" -> mem_addr=0x100 in FETCH; WB cycle has reg_waddr=1, reg_wdata=0xFFFFFFFB; pc=0x104; retired=1 after 4 cycles.
- lw $2,8($1) with rd1=0x200, mem_ready low 3 cycles in MEM -> mem_read/mem_addr=0x208 held 4 cycles; reg_wdata=mem_rdata; total 8 cycles.
- beq with rd1=rd2=7, imm=0xFFFF at pc=0x40 -> next fetch address 0x40; bne same operands -> 0x44; each 3 cycles.
- Opcode 0x3F -> halted=1, no mem_read for 20 cycles, retired unchanged; then assert rst_n low mid-FETCH stall -> state=0, pc=RESET_PC, mem_read=0 immediately.
- "add $0,$3,$4" then funct 0x3E -> no reg_write for either; illegal pulses once; retired increments by 2.
- XLEN=64, CNT_W=4: 16 retired instructions -> retired wraps to 0; sext of imm 0x8000 gives 0xFFFFFFFFFFFF8000.
